// File: rtl/rs_station_pkg.sv
// Shared definitions for the ALU reservation station: sizes, opcode
// encodings, the per-entry record and the CDB operand-snoop helper.
package rs_station_pkg;

    localparam int RS_SIZE = 8;
    localparam int RS_BIT  = $clog2(RS_SIZE);
    localparam int ROB_BIT = 3;
    localparam int XLEN    = 32;
    localparam int OP_W    = 5;

    // ALU opcode encodings carried through the station untouched
    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } alu_op_e;

    // One source operand: either a value (rdy=1) or still waiting on a tag
    typedef struct packed {
        logic            rdy;
        logic [XLEN-1:0] val;
    } operand_t;

    // One reservation-station slot
    typedef struct packed {
        logic               busy;
        logic [OP_W-1:0]    op;
        logic [XLEN-1:0]    vj;
        logic [XLEN-1:0]    vk;
        logic [ROB_BIT-1:0] qj;
        logic [ROB_BIT-1:0] qk;
        logic               qj_rdy;
        logic               qk_rdy;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic [ROB_BIT-1:0] rob;
    } rs_entry_t;

    // Resolve a waiting operand against both CDB ports; the ALU port is
    // checked first so it wins when both carry the same tag.
    function automatic operand_t snoop_operand(
        input logic               rdy,
        input logic [XLEN-1:0]    val,
        input logic [ROB_BIT-1:0] tag,
        input logic               alu_v,
        input logic [ROB_BIT-1:0] alu_tag,
        input logic [XLEN-1:0]    alu_val,
        input logic               lsb_v,
        input logic [ROB_BIT-1:0] lsb_tag,
        input logic [XLEN-1:0]    lsb_val
    );
        operand_t res;
        res.rdy = rdy;
        res.val = val;
        if (!rdy) begin
            if (alu_v && (alu_tag == tag)) begin
                res.rdy = 1'b1;
                res.val = alu_val;
            end else if (lsb_v && (lsb_tag == tag)) begin
                res.rdy = 1'b1;
                res.val = lsb_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_station_chooser.sv
// Lowest-index slot selection for the reservation station: picks the free
// slot for issue and the prepared slot for dispatch. Purely combinational.
module rs_station_chooser
    import rs_station_pkg::*;
(
    input  logic [RS_SIZE-1:0] busy_i,
    input  logic [RS_SIZE-1:0] prepared_i,
    output logic [RS_BIT-1:0]  issue_entry_o,
    output logic               full_o,
    output logic [RS_BIT-1:0]  rs_entry_o,
    output logic               ready_o
);

    // Scan from the top down so the lowest matching index is the last write
    always_comb begin
        issue_entry_o = '0;
        rs_entry_o    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_i[i]) begin
                issue_entry_o = RS_BIT'(i);
            end
            if (prepared_i[i]) begin
                rs_entry_o = RS_BIT'(i);
            end
        end
    end

    assign full_o  = &busy_i;
    assign ready_o = |prepared_i;

endmodule

// File: rtl/rs_station.sv
// ALU reservation station: issue into the lowest free slot, operand capture
// from the ALU and LSB CDB ports, lowest-index dispatch to the ALU.
// Optional build macro: RS_ISSUE_BYPASS_EN -- when defined, an issuing
// operand that is not ready is resolved against the same-cycle CDB tags.
//
// Handshake: issue_valid is a one-cycle request accepted at the rising edge
// whenever rs_full is low (a request while rs_full is high is dropped);
// alu_valid is a one-cycle strobe with no back-pressure from the ALU.
// Everything is frozen while rdy_in is low, including flush.
module rs_station
    import rs_station_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               rdy_in,
    input  logic               flush_in,

    input  logic               issue_valid,
    input  logic [OP_W-1:0]    issue_op,
    input  logic               issue_qj_rdy,
    input  logic [XLEN-1:0]    issue_vj,
    input  logic [ROB_BIT-1:0] issue_qj,
    input  logic               issue_qk_rdy,
    input  logic [XLEN-1:0]    issue_vk,
    input  logic [ROB_BIT-1:0] issue_qk,
    input  logic [XLEN-1:0]    issue_imm,
    input  logic [XLEN-1:0]    issue_pc,
    input  logic [ROB_BIT-1:0] issue_rob,
    output logic               rs_full,

    input  logic               cdb_alu_valid,
    input  logic [ROB_BIT-1:0] cdb_alu_tag,
    input  logic [XLEN-1:0]    cdb_alu_val,
    input  logic               cdb_lsb_valid,
    input  logic [ROB_BIT-1:0] cdb_lsb_tag,
    input  logic [XLEN-1:0]    cdb_lsb_val,

    output logic               alu_valid,
    output logic [OP_W-1:0]    alu_op,
    output logic [XLEN-1:0]    alu_vj,
    output logic [XLEN-1:0]    alu_vk,
    output logic [XLEN-1:0]    alu_imm,
    output logic [XLEN-1:0]    alu_pc,
    output logic [ROB_BIT-1:0] alu_rob
);

    rs_entry_t          entry_q [RS_SIZE];
    rs_entry_t          entry_d [RS_SIZE];

    logic               alu_valid_q, alu_valid_d;
    logic [OP_W-1:0]    alu_op_q,    alu_op_d;
    logic [XLEN-1:0]    alu_vj_q,    alu_vj_d;
    logic [XLEN-1:0]    alu_vk_q,    alu_vk_d;
    logic [XLEN-1:0]    alu_imm_q,   alu_imm_d;
    logic [XLEN-1:0]    alu_pc_q,    alu_pc_d;
    logic [ROB_BIT-1:0] alu_rob_q,   alu_rob_d;

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] prepared_vec;
    logic [RS_BIT-1:0]  issue_idx;
    logic [RS_BIT-1:0]  disp_idx;
    logic               full;
    logic               any_prepared;

    // Busy/prepared vectors from the registered slot state only
    always_comb begin
        busy_vec     = '0;
        prepared_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]     = entry_q[i].busy;
            prepared_vec[i] = entry_q[i].busy & entry_q[i].qj_rdy & entry_q[i].qk_rdy;
        end
    end

    rs_station_chooser u_chooser (
        .busy_i        (busy_vec),
        .prepared_i    (prepared_vec),
        .issue_entry_o (issue_idx),
        .full_o        (full),
        .rs_entry_o    (disp_idx),
        .ready_o       (any_prepared)
    );

    assign rs_full = full;

    // Next-state: capture on busy slots, issue into the free slot, dispatch
    // the prepared slot; flush overrides all three.
    always_comb begin
        rs_entry_t new_e;
        operand_t  opj;
        operand_t  opk;

        for (int i = 0; i < RS_SIZE; i++) begin
            entry_d[i] = entry_q[i];
        end
        alu_valid_d = 1'b0;
        alu_op_d    = alu_op_q;
        alu_vj_d    = alu_vj_q;
        alu_vk_d    = alu_vk_q;
        alu_imm_d   = alu_imm_q;
        alu_pc_d    = alu_pc_q;
        alu_rob_d   = alu_rob_q;

        new_e.busy   = 1'b1;
        new_e.op     = issue_op;
        new_e.vj     = issue_vj;
        new_e.vk     = issue_vk;
        new_e.qj     = issue_qj;
        new_e.qk     = issue_qk;
        new_e.qj_rdy = issue_qj_rdy;
        new_e.qk_rdy = issue_qk_rdy;
        new_e.imm    = issue_imm;
        new_e.pc     = issue_pc;
        new_e.rob    = issue_rob;
`ifdef RS_ISSUE_BYPASS_EN
        opj = snoop_operand(issue_qj_rdy, issue_vj, issue_qj,
                            cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                            cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
        opk = snoop_operand(issue_qk_rdy, issue_vk, issue_qk,
                            cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                            cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
        new_e.qj_rdy = opj.rdy;
        new_e.vj     = opj.val;
        new_e.qk_rdy = opk.rdy;
        new_e.vk     = opk.val;
`else
        opj = '0;
        opk = '0;
`endif

        if (flush_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_d[i].busy = 1'b0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                opj = snoop_operand(entry_q[i].qj_rdy, entry_q[i].vj, entry_q[i].qj,
                                    cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                    cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
                opk = snoop_operand(entry_q[i].qk_rdy, entry_q[i].vk, entry_q[i].qk,
                                    cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                    cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
                if (entry_q[i].busy) begin
                    entry_d[i].qj_rdy = opj.rdy;
                    entry_d[i].vj     = opj.val;
                    entry_d[i].qk_rdy = opk.rdy;
                    entry_d[i].vk     = opk.val;
                end
            end

            // The free slot is never the dispatching slot, so these cannot collide
            if (issue_valid && !full) begin
                entry_d[issue_idx] = new_e;
            end

            if (any_prepared) begin
                alu_valid_d             = 1'b1;
                alu_op_d                = entry_q[disp_idx].op;
                alu_vj_d                = entry_q[disp_idx].vj;
                alu_vk_d                = entry_q[disp_idx].vk;
                alu_imm_d               = entry_q[disp_idx].imm;
                alu_pc_d                = entry_q[disp_idx].pc;
                alu_rob_d               = entry_q[disp_idx].rob;
                entry_d[disp_idx].busy  = 1'b0;
            end
        end
    end

    // State registers; rdy_in low freezes slots and dispatch outputs alike
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_vj_q    <= '0;
            alu_vk_q    <= '0;
            alu_imm_q   <= '0;
            alu_pc_q    <= '0;
            alu_rob_q   <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= entry_d[i];
            end
            alu_valid_q <= alu_valid_d;
            alu_op_q    <= alu_op_d;
            alu_vj_q    <= alu_vj_d;
            alu_vk_q    <= alu_vk_d;
            alu_imm_q   <= alu_imm_d;
            alu_pc_q    <= alu_pc_d;
            alu_rob_q   <= alu_rob_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_op    = alu_op_q;
    assign alu_vj    = alu_vj_q;
    assign alu_vk    = alu_vk_q;
    assign alu_imm   = alu_imm_q;
    assign alu_pc    = alu_pc_q;
    assign alu_rob   = alu_rob_q;

endmodule
